seg7_scan_ctrl: RTL and testbench

- Avalon-MM slave that owns the alarm-clock seven-segment display.
- Holds four BCD digits plus blink/blank masks, and time-multiplexes them onto one shared segment bus with one-hot digit enables.
- Sits on the NIOS data bus beside the single-digit LED PIOs.
- Replaces per-digit software writes with hardware scan sequencing, blink timing and an anti-ghosting gap between digits.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   - Register offsets of the Avalon-MM slave.
//   - Scan state encoding.
//   - Active-high segment constants and the 16-entry BCD pattern table.
//     Bit order is bit0=a ... bit6=g.
package seg7_pkg;

    localparam logic [1:0] REG_DIGITS = 2'd0;
    localparam logic [1:0] REG_MASKS  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Digits 0-9 use the usual patterns. Non-BCD codes A-F show a dash, so a
    // bad software write is visible instead of rendering as a hex letter.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder.
// The output is always active high. Pin polarity belongs to whoever drives
// the display, so this block can also serve the direct-drive PIO digits.
// Ports:
//   bcd  in  4  digit code (0-9 valid, A-F decode to a dash)
//   seg  out 7  segment pattern, bit0=a ... bit6=g, active high
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Avalon-MM slave that drives the alarm-clock seven-segment display.
// It holds NUM_DIGITS BCD digits plus blink and blank masks. The digits are
// time-multiplexed onto one shared segment bus. Each digit slot lasts
// SCAN_DIV cycles: SCAN_DIV-1 cycles lit, then one dark cycle that stops
// ghosting between neighbouring digits.
// Ports:
//   clk, reset_n      clock; asynchronous active-low reset
//   address[1:0]      0 DIGITS, 1 MASKS, 2 CTRL, 3 STATUS (read only)
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[31:0]   write data
//   readdata[31:0]    combinational read data, zero wait states
//   seg_out[6:0]      segments a..g, inverted when SEG_ACTIVE_LOW
//   dig_sel[N-1:0]    one-hot digit enable, active high
//   frame_tick        one-cycle pulse in the dark cycle where the index wraps
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_tick
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0]         digits_q, digits_d;
    logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;
    logic [NUM_DIGITS-1:0] blank_mask_q, blank_mask_d;
    logic                  enable_q, enable_d;

    scan_state_e           state_q, state_d;
    logic [2:0]            index_q, index_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  blink_phase_q, blink_phase_d;

    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [3:0]            nib_sel;
    logic                  blink_bit;
    logic                  blank_bit;
    logic [6:0]            dec_seg;

    // Only the low DW bits of writedata are stored. Reducing the whole bus
    // keeps the remaining bits from showing up as dangling inputs.
    logic                  unused_wdata;
    assign unused_wdata = ^writedata;

    // Register file writes.
    always_comb begin
        digits_d     = digits_q;
        blink_mask_d = blink_mask_q;
        blank_mask_d = blank_mask_q;
        enable_d     = enable_q;
        if (chipselect && !write_n) begin
            case (address)
                REG_DIGITS: digits_d = writedata[DW-1:0];
                REG_MASKS: begin
                    blink_mask_d = writedata[NUM_DIGITS-1:0];
                    blank_mask_d = writedata[8 +: NUM_DIGITS];
                end
                REG_CTRL: enable_d = writedata[0];
                default: ;
            endcase
        end
    end

    // Scan sequencing and blink timing.
    // Start-up waits for the enable register. Shutdown reacts to the write
    // itself, so the display goes dark on the cycle right after the CTRL write.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        presc_d       = presc_q;
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        case (state_q)
            IDLE: begin
                if (enable_q && enable_d) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (presc_q == PW'(SCAN_DIV - 2)) begin
                    state_d = GAP;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            GAP: begin
                state_d = SHOW;
                if (index_q == 3'(NUM_DIGITS - 1)) begin
                    index_d = '0;
                    if (frame_q == FW'(BLINK_DIV - 1)) begin
                        frame_d       = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        frame_d = frame_q + FW'(1);
                    end
                end else begin
                    index_d = index_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable_d) begin
            state_d       = IDLE;
            index_d       = '0;
            presc_d       = '0;
            frame_d       = '0;
            blink_phase_d = 1'b0;
        end
    end

    // Select the digit data for the slot about to be shown. The outputs are
    // registered from next-state values, so dig_sel and seg_out line up with
    // the state register. A digit or mask write reaches the pins one cycle
    // after the bus cycle that wrote it.
    always_comb begin
        nib_sel   = '0;
        blink_bit = 1'b0;
        blank_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_d == 3'(i)) begin
                nib_sel   = digits_d[4*i +: 4];
                blink_bit = blink_mask_d[i];
                blank_bit = blank_mask_d[i];
            end
        end
    end

    seg7_decode u_decode (
        .bcd (nib_sel),
        .seg (dec_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        if (state_d == SHOW && !blank_bit && !(blink_bit && blink_phase_d)) begin
            seg_d = dec_seg;
        end
        frame_tick_d = (state_d == GAP) && (index_d == 3'(NUM_DIGITS - 1));
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_sel
        assign dig_sel_d[gi] = (state_d == SHOW) && (index_d == 3'(gi));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q      <= '0;
            blink_mask_q  <= '0;
            blank_mask_q  <= '0;
            enable_q      <= 1'b0;
            state_q       <= IDLE;
            index_q       <= '0;
            presc_q       <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dig_sel_q     <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            digits_q      <= digits_d;
            blink_mask_q  <= blink_mask_d;
            blank_mask_q  <= blank_mask_d;
            enable_q      <= enable_d;
            state_q       <= state_d;
            index_q       <= index_d;
            presc_q       <= presc_d;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    // Read path: combinational, unused bits zero, no side effects.
    always_comb begin
        readdata = '0;
        case (address)
            REG_DIGITS: readdata[DW-1:0] = digits_q;
            REG_MASKS: begin
                readdata[NUM_DIGITS-1:0]  = blink_mask_q;
                readdata[8 +: NUM_DIGITS] = blank_mask_q;
            end
            REG_CTRL: readdata[0] = enable_q;
            default: begin
                readdata[2:0] = index_q;
                readdata[8]   = blink_phase_q;
                readdata[9]   = (state_q != IDLE);
            end
        endcase
    end

    assign seg_out    = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl, configured with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2 and active-high segments.
// Expected values come from a per-cycle model of the scan timing. They are
// queued as each cycle is set up and compared once the DUT output is sampled.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BD = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [6:0]   seg_out;
    logic [N-1:0] dig_sel;
    logic         frame_tick;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (SD),
        .BLINK_DIV      (BD),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, got, e.val);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("[TB] write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        push_exp(tag, exp);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        $display("[TB] read  addr=%0d data=0x%08h", a, readdata);
        pop_check(readdata);
        chipselect = 1'b0;
    endtask

    // Check the idle outputs right after a CTRL write returns.
    task automatic check_dark(input string tag, input logic [31:0] exp_status);
        address = 2'd3;
        #1;
        push_exp({tag, " dig_sel"}, 32'd0);
        push_exp({tag, " seg_out"}, 32'd0);
        push_exp({tag, " status"}, exp_status);
        pop_check(32'(dig_sel));
        pop_check(32'(seg_out));
        pop_check(readdata);
    endtask

    // Model the scan from the first lit cycle after enabling (cycle 0).
    task automatic run_scan(input int ncyc, input logic [15:0] digs,
                            input logic [3:0] blink, input logic [3:0] blank);
        address = 2'd3;
        for (int c = 0; c < ncyc; c++) begin
            int          slot;
            int          pos;
            int          d;
            int          frame;
            logic        phase;
            logic [6:0]  s;
            logic [31:0] st;
            slot  = c / SD;
            pos   = c % SD;
            d     = slot % N;
            frame = slot / N;
            phase = ((frame / BD) % 2) == 1;
            s     = ref_seg(digs[4*d +: 4]);
            if (blank[d] || (blink[d] && phase) || pos == SD - 1) s = 7'h00;
            st    = 32'(d) | (32'(phase) << 8) | (32'd1 << 9);
            push_exp($sformatf("c%0d dig_sel", c), (pos < SD - 1) ? (32'd1 << d) : 32'd0);
            push_exp($sformatf("c%0d seg_out", c), 32'(s));
            push_exp($sformatf("c%0d frame_tick", c), 32'((pos == SD - 1) && (d == N - 1)));
            push_exp($sformatf("c%0d status", c), st);
            @(negedge clk);
            pop_check(32'(dig_sel));
            pop_check(32'(seg_out));
            pop_check(32'(frame_tick));
            pop_check(readdata);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        push_exp("rst seg_out", 32'd0);
        push_exp("rst dig_sel", 32'd0);
        push_exp("rst frame_tick", 32'd0);
        pop_check(32'(seg_out));
        pop_check(32'(dig_sel));
        pop_check(32'(frame_tick));
        reset_n = 1'b1;

        for (int a = 0; a < 4; a++) begin
            bus_read_check(2'(a), 32'd0, $sformatf("reset read addr%0d", a));
        end

        // Register access, unused bits and the read-only STATUS register.
        bus_write(2'd0, 32'hFFFF_1234);
        bus_read_check(2'd0, 32'h0000_1234, "digits readback");
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read_check(2'd1, 32'h0000_0F0F, "masks readback");
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read_check(2'd3, 32'd0, "status write ignored");
        bus_read_check(2'd2, 32'd0, "ctrl after status write");
        bus_write(2'd2, 32'hFFFF_FFFE);
        bus_read_check(2'd2, 32'd0, "ctrl bit0 only");
        bus_write(2'd1, 32'd0);

        // Plain scan order and frame ticks.
        bus_write(2'd2, 32'd1);
        check_dark("prestart1", 32'd0);
        run_scan(64, 16'h1234, 4'h0, 4'h0);

        // Dash decode, blink of digit 0, blank of digit 1.
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h0000_567B);
        bus_write(2'd1, 32'h0000_0201);
        bus_write(2'd2, 32'd1);
        check_dark("prestart2", 32'd0);
        run_scan(64, 16'h567B, 4'h1, 4'h2);

        // Disable during digit 2, then restart from digit 0.
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h0000_9008);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd1);
        check_dark("prestart3", 32'd0);
        run_scan(9, 16'h9008, 4'h0, 4'h0);
        bus_write(2'd2, 32'd0);
        check_dark("disabled", 32'd0);
        bus_write(2'd2, 32'd1);
        check_dark("prestart4", 32'd0);
        run_scan(38, 16'h9008, 4'h0, 4'h0);

        // Asynchronous reset while digit 1 is lit.
        #2;
        reset_n = 1'b0;
        #1;
        push_exp("async rst dig_sel", 32'd0);
        push_exp("async rst seg_out", 32'd0);
        push_exp("async rst frame_tick", 32'd0);
        push_exp("async rst status", 32'd0);
        pop_check(32'(dig_sel));
        pop_check(32'(seg_out));
        pop_check(32'(frame_tick));
        pop_check(readdata);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read_check(2'(a), 32'd0, $sformatf("post rst addr%0d", a));
        end
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
